// File: rtl/operand_sequencer.sv
// operand_sequencer: front end for the registered adder stage.
// Syncs and debounces the Enter key, then steps a small FSM through
// A capture, B capture and a one-cycle Load strobe toward the adder.
module operand_sequencer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             CLOCK_50,
  input  logic             Reset,
  input  logic [WIDTH-1:0] SW,
  input  logic             Enter_n,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             Load,
  output logic [1:0]       Phase
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    GET_A = 2'b00,
    GET_B = 2'b01,
    ISSUE = 2'b10,
    SHOW  = 2'b11
  } state_t;

  logic          sync0_q, sync1_q;
  logic          lvl_q, lvl_d;
  logic          lvl_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic            load_q, load_d;

  // Debounce: count cycles of disagreement; any agreement restarts the count.
  // The level flips on the edge the count would reach DEBOUNCE_CYCLES.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (sync1_q != lvl_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) lvl_d = ~lvl_q;
      else                                   cnt_d = cnt_q + CW'(1);
    end
    // Press fires one cycle after the level has fallen; releases are silent.
    press_d = lvl_dly_q & ~lvl_q;
  end

  // Synchronizer, debouncer and press-pulse registers.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      sync0_q   <= 1'b1;
      sync1_q   <= 1'b1;
      lvl_q     <= 1'b1;
      lvl_dly_q <= 1'b1;
      cnt_q     <= '0;
      press_q   <= 1'b0;
    end else begin
      sync0_q   <= Enter_n;
      sync1_q   <= sync0_q;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_q;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
    end
  end

  // Next-state and operand capture; a press seen in ISSUE is dropped.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      GET_A: if (press_q) begin a_d = SW; state_d = GET_B; end
      GET_B: if (press_q) begin b_d = SW; state_d = ISSUE; end
      ISSUE: state_d = SHOW;
      SHOW:  if (press_q) begin a_d = SW; state_d = GET_B; end
      default: state_d = GET_A;
    endcase
    // Load is registered alongside the state so it is high exactly in ISSUE.
    load_d = (state_d == ISSUE);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      load_q  <= load_d;
    end
  end

  assign A     = a_q;
  assign B     = b_q;
  assign Load  = load_q;
  assign Phase = state_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer with DEBOUNCE_CYCLES=4.
// A press with an idle debouncer takes effect on the 8th posedge (edge 7)
// counting the first edge that samples the low key as edge 0.
module tb_operand_sequencer;
  localparam int W = 8;
  localparam int N = 4;

  logic         CLOCK_50 = 1'b0;
  logic         Reset    = 1'b1;
  logic [W-1:0] SW       = '0;
  logic         Enter_n  = 1'b1;
  logic [W-1:0] A, B;
  logic         Load;
  logic [1:0]   Phase;

  int n_vec = 0;
  int n_err = 0;

  operand_sequencer #(.WIDTH(W), .DEBOUNCE_CYCLES(N)) dut (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .SW       (SW),
    .Enter_n  (Enter_n),
    .A        (A),
    .B        (B),
    .Load     (Load),
    .Phase    (Phase)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // advance one clock and settle just after the edge
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  // key already low for 8 edges: keep it low to 20 cycles, then release and settle
  task automatic hold_release();
    step(12);
    Enter_n = 1'b1;
    step(10);
  endtask

  initial begin
    // reset state
    step(1);
    Reset = 1'b0;
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_Load", Load, 0);
    chk("rst_Phase", Phase, 0);

    // basic pair
    SW = 8'h3C; Enter_n = 1'b0;
    step(7);
    chk("s1_A_early", A, 0);
    chk("s1_Ph_early", Phase, 0);
    step(1);
    chk("s1_A", A, 8'h3C);
    chk("s1_Ph_getb", Phase, 2'b01);
    chk("s1_B_kept", B, 0);
    hold_release();
    chk("s1_rel_Ph", Phase, 2'b01);
    chk("s1_rel_A", A, 8'h3C);
    SW = 8'hA5; Enter_n = 1'b0;
    step(7);
    chk("s1_B_early", B, 0);
    chk("s1_Load_early", Load, 0);
    step(1);
    chk("s1_B", B, 8'hA5);
    chk("s1_Load", Load, 1);
    chk("s1_Ph_issue", Phase, 2'b10);
    step(1);
    chk("s1_Load_fall", Load, 0);
    chk("s1_Ph_show", Phase, 2'b11);
    hold_release();
    chk("s1_show_A", A, 8'h3C);
    chk("s1_show_B", B, 8'hA5);
    chk("s1_show_Ph", Phase, 2'b11);

    // new pair from SHOW
    SW = 8'hFF; Enter_n = 1'b0;
    step(7);
    chk("s3_A_early", A, 8'h3C);
    step(1);
    chk("s3_A", A, 8'hFF);
    chk("s3_B", B, 8'hA5);
    chk("s3_Ph", Phase, 2'b01);
    chk("s3_Load", Load, 0);
    hold_release();

    // reset mid-entry
    Reset = 1'b1; step(1); Reset = 1'b0;
    SW = 8'h12; Enter_n = 1'b0;
    step(8);
    chk("s4_A", A, 8'h12);
    chk("s4_Ph", Phase, 2'b01);
    hold_release();
    Reset = 1'b1; step(1); Reset = 1'b0;
    chk("s4_rst_A", A, 0);
    chk("s4_rst_B", B, 0);
    chk("s4_rst_Ph", Phase, 0);
    chk("s4_rst_Load", Load, 0);

    // bounce rejection; next press lands in A after reset
    SW = 8'h5A;
    Enter_n = 1'b0; step(1);
    Enter_n = 1'b1; step(1);
    Enter_n = 1'b0; step(1);
    Enter_n = 1'b1; step(1);
    Enter_n = 1'b0;
    step(7);
    chk("s2_A_early", A, 0);
    chk("s2_Ph_early", Phase, 0);
    step(1);
    chk("s2_A", A, 8'h5A);
    chk("s2_Ph", Phase, 2'b01);
    hold_release();
    chk("s2_one_event", Phase, 2'b01);
    // 3-cycle glitch must not produce a press
    SW = 8'hC3;
    Enter_n = 1'b0; step(3);
    Enter_n = 1'b1; step(12);
    chk("s2_glitch_Ph", Phase, 2'b01);
    chk("s2_glitch_B", B, 0);
    chk("s2_glitch_Load", Load, 0);

    // held through reset
    SW = 8'h33; Enter_n = 1'b0;
    Reset = 1'b1; step(3); Reset = 1'b0;
    chk("s5_rst_Ph", Phase, 0);
    step(7);
    chk("s5_Ph_early", Phase, 0);
    chk("s5_A_early", A, 0);
    step(1);
    chk("s5_Ph", Phase, 2'b01);
    chk("s5_A", A, 8'h33);
    step(30);
    chk("s5_hold_Ph", Phase, 2'b01);
    chk("s5_hold_B", B, 0);
    Enter_n = 1'b1; step(10);
    SW = 8'h77; Enter_n = 1'b0;
    step(8);
    chk("s5_B", B, 8'h77);
    chk("s5_Load", Load, 1);
    step(1);
    chk("s5_Load_fall", Load, 0);
    chk("s5_Ph_show", Phase, 2'b11);
    hold_release();

    // switch churn with key released
    for (int i = 0; i < 50; i++) begin
      SW = W'($urandom);
      step(1);
      chk("s6_Ph", Phase, 2'b11);
      chk("s6_Load", Load, 0);
    end
    step(N + 4);
    chk("s6_A", A, 8'h33);
    chk("s6_B", B, 8'h77);
    chk("s6_Ph_end", Phase, 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/operand_sequencer.md
# operand_sequencer

Upstream front end for the registered 8-bit adder stage. It turns a single raw Enter push button and the operand switches into a clean two-operand entry sequence. The first debounced press captures operand A and the second captures operand B. The block then issues a one-cycle Load strobe with both operands stable, which the adder stage consumes.

## Interface
Parameters:
- WIDTH, 8: operand width in bits.
- DEBOUNCE_CYCLES, 500000: consecutive stable clock cycles required before a key level change is accepted (10 ms at 50 MHz).

Ports:
- CLOCK_50  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  reset; one clock, reset is synchronous and active-high.
- SW  in  WIDTH  operand switches; sampled directly, with no synchronizer (quasi-static).
- Enter_n  in  1  raw push button, active-low, asynchronous and bouncy.
- A  out  WIDTH  registered operand A.
- B  out  WIDTH  registered operand B.
- Load  out  1  one-cycle strobe: A and B are valid for the adder stage.
- Phase  out  2  FSM state: 00 GET_A, 01 GET_B, 10 ISSUE, 11 SHOW.

## Operation
- **Synchronizer:** two flops on Enter_n, both reset to 1.
- **Debouncer:**
  - Holds a debounced level, reset 1 (released), and a counter, reset 0.
  - Counter increments every cycle in which the synchronized input differs from the debounced level.
  - Counter clears to 0 in any cycle where the synchronized input equals the debounced level, so any bounce restarts the count.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears on that edge.
- **Press event:** a 1-cycle registered pulse, asserted in the cycle after the debounced level goes 1→0. A release (0→1) generates no event.
- **FSM:**
  - GET_A: on press, A←SW, B unchanged, go to GET_B.
  - GET_B: on press, B←SW, go to ISSUE.
  - ISSUE: Load=1 for exactly this one cycle, then go unconditionally to SHOW. A press event in this cycle is ignored.
  - SHOW: A and B are held. On press, A←SW (start of a new pair) and go to GET_B.
- Load is high only in ISSUE and is never asserted for two consecutive cycles.
- A and B change only on a press-event edge or on Reset.
- **Reset values:** A=0, B=0, Load=0, Phase=00, debounced level=1, counter=0, press pulse=0.
  - Reset mid-operation discards any partial pair and any in-progress debounce count.
- A key held low through Reset produces exactly one press event DEBOUNCE_CYCLES+3 edges after Reset deasserts.

## Timing
- **Press latency:** Enter_n is low and stable from before edge 0, with the debouncer idle (level 1, counter 0).
  - The synchronized input is 0 after edge 1.
  - The debounced level flips at edge N+1 (N=DEBOUNCE_CYCLES).
  - The press pulse is high after edge N+2.
  - A, B or Phase update at edge N+3.
- **Load:** rises on the edge that enters ISSUE, which is the same edge that captures B, and falls on the next edge.
- **Release latency:** N+1 edges; no output changes.
- **Minimum press-to-press spacing:** 2N+2 cycles (press debounce plus release debounce).
- Reset takes effect at the first rising edge with Reset=1 and overrides every other event in that cycle.

## Test plan
(DEBOUNCE_CYCLES=4 for all scenarios.)
1. **Basic pair:** Reset, then SW=0x3C and a clean press held 20 cycles, release, then SW=0xA5 and a press.
   - Required: A=0x3C at press edge +7; B=0xA5 at the second press edge +7; Load high exactly 1 cycle at that same edge.
   - Phase sequence: 00→01→10→11.
2. **Bounce rejection:** Enter_n toggles 0/1/0/1/0 with a 2-cycle period, then stays low.
   - Required: one press event only; A captured 7 edges after the final stable low.
   - A glitch of 3 cycles or fewer produces no event.
3. **New pair from SHOW:** in SHOW (A=0x3C, B=0xA5), press with SW=0xFF.
   - Required: A=0xFF, B stays 0xA5, Phase=01, no Load.
4. **Reset mid-entry:** press with SW=0x12 so A=0x12 and Phase=01, then assert Reset for 1 cycle.
   - Required: A=0, B=0, Phase=00, Load=0; the next press captures into A.
5. **Held through reset:** Enter_n low before and during Reset.
   - Required: exactly one press event, 7 edges after Reset deasserts; no second event until release and re-press.
6. **Switch change without press:** SW changes every cycle for 50 cycles with the key released.
   - Required: A, B, Phase and Load all unchanged.
